// File: rtl/axi_write_ctrl_pkg.sv
// axi_wr_pkg: FSM states, W_state route codes and BRESP codes shared by the write-path controller and muxes
package axi_wr_pkg;
  typedef enum logic [1:0] {IDLE, AW, W, B} wr_fsm_e;
  localparam logic [1:0] WS_IDLE = 2'd0;
  localparam logic [1:0] WS_M1_S0 = 2'd1;
  localparam logic [1:0] WS_M1_S1 = 2'd2;
  localparam logic [1:0] WS_M1_DEF = 2'd3;
  localparam logic [1:0] BRESP_OKAY = 2'b00;
  localparam logic [1:0] BRESP_DECERR = 2'b11;
endpackage

// File: rtl/axi_write_ctrl_if.sv
// axi_write_ctrl_if: M1 write handshakes (master drives AW/W/B inputs) and controller outputs (route code, route enables, wlast_err, default-slave *_DEC)
interface axi_write_ctrl_if;
  logic [31:0] AWADDR_M1;
  logic [3:0] AWLEN_M1;
  logic AWVALID_M1, AWREADY_M1, WVALID_M1, WREADY_M1, WLAST_M1, BVALID_M1, BREADY_M1;
  logic [1:0] W_state;
  logic aw_route, w_route, b_route, wlast_err;
  logic AWREADY_DEC, WREADY_DEC, BVALID_DEC;
  logic [1:0] BRESP_DEC;
  modport master (
    output AWADDR_M1, AWLEN_M1, AWVALID_M1, AWREADY_M1, WVALID_M1, WREADY_M1, WLAST_M1, BVALID_M1, BREADY_M1,
    input W_state, aw_route, w_route, b_route, wlast_err, AWREADY_DEC, WREADY_DEC, BVALID_DEC, BRESP_DEC
  );
  modport slave (
    input AWADDR_M1, AWLEN_M1, AWVALID_M1, AWREADY_M1, WVALID_M1, WREADY_M1, WLAST_M1, BVALID_M1, BREADY_M1,
    output W_state, aw_route, w_route, b_route, wlast_err, AWREADY_DEC, WREADY_DEC, BVALID_DEC, BRESP_DEC
  );
endinterface

// File: rtl/axi_write_ctrl_addr_decode.sv
// axi_wr_addr_decode: combinational addr -> route code (S0/S1 windows; unmapped -> DEFAULT with AXI_WR_DECERR_EN, else S1)
module axi_wr_addr_decode
  import axi_wr_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] WIN_MASK = 32'hFFFF_0000
) (
  input logic [31:0] addr,
  output logic [1:0] route
);
`ifdef AXI_WR_DECERR_EN
  localparam logic [1:0] UNMAPPED = WS_M1_DEF;
`else
  localparam logic [1:0] UNMAPPED = WS_M1_S1;
`endif
  logic [31:0] win;
  assign win = addr & WIN_MASK;
  assign route = win == S0_BASE ? WS_M1_S0 : win == S1_BASE ? WS_M1_S1 : UNMAPPED;
endmodule

// File: rtl/axi_write_ctrl.sv
// axi_write_ctrl: M1 write sequencer IDLE->AW->W->B holding W_state per transaction; ports ACLK, ARESET, bus (slave modport); AXI_WR_DECERR_EN adds default slave
module axi_write_ctrl
  import axi_wr_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] WIN_MASK = 32'hFFFF_0000
) (
  input logic ACLK,
  input logic ARESET,
  axi_write_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_AW = AW;
  localparam logic [1:0] ST_W = W;
  localparam logic [1:0] ST_B = B;
  logic [1:0] st, ws, route;
  logic [3:0] beat_cnt;
  logic err, aw_hs, w_hs, b_hs, last;
  axi_wr_addr_decode #(.S0_BASE(S0_BASE), .S1_BASE(S1_BASE), .WIN_MASK(WIN_MASK)) u_dec (
    .addr(bus.AWADDR_M1),
    .route(route)
  );
  assign aw_hs = bus.AWVALID_M1 & bus.AWREADY_M1;
  assign w_hs = bus.WVALID_M1 & bus.WREADY_M1;
  assign b_hs = bus.BVALID_M1 & bus.BREADY_M1;
  assign last = beat_cnt == 4'd0;
  // beat_cnt alone ends the burst; WLAST is only cross-checked
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      st <= ST_IDLE;
      ws <= WS_IDLE;
      beat_cnt <= '0;
      err <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (bus.AWVALID_M1) begin
          ws <= route;
          st <= ST_AW;
        end
        ST_AW: if (aw_hs) begin
          beat_cnt <= bus.AWLEN_M1;
          st <= ST_W;
        end
        ST_W: if (w_hs) begin
          if (last) st <= ST_B;
          else beat_cnt <= beat_cnt - 4'd1;
          if (bus.WLAST_M1 != last) err <= 1'b1;
        end
        default: if (b_hs) begin
          ws <= WS_IDLE;
          st <= ST_IDLE;
        end
      endcase
    end
  end
  assign bus.W_state = ws;
  assign bus.aw_route = st == ST_AW;
  assign bus.w_route = st == ST_W;
  assign bus.b_route = st == ST_B;
  assign bus.wlast_err = err;
`ifdef AXI_WR_DECERR_EN
  logic dec;
  assign dec = ws == WS_M1_DEF;
  assign bus.AWREADY_DEC = dec & (st == ST_AW);
  assign bus.WREADY_DEC = dec & (st == ST_W);
  assign bus.BVALID_DEC = dec & (st == ST_B);
  assign bus.BRESP_DEC = dec & (st == ST_B) ? BRESP_DECERR : BRESP_OKAY;
`else
  assign bus.AWREADY_DEC = 1'b0;
  assign bus.WREADY_DEC = 1'b0;
  assign bus.BVALID_DEC = 1'b0;
  assign bus.BRESP_DEC = BRESP_OKAY;
`endif
endmodule

// File: tb/tb_axi_write_ctrl.sv
// tb_axi_write_ctrl: directed and random write transactions checked against a transaction-level protocol model
module tb_axi_write_ctrl;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;
  axi_write_ctrl_if bus();
  axi_write_ctrl dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic exp_err = 1'b0;
`ifdef AXI_WR_DECERR_EN
  localparam int UNM = 3;
`else
  localparam int UNM = 2;
`endif
  function automatic int exp_route(logic [31:0] a);
    if (a[31:16] == 16'h0000) return 1;
    if (a[31:16] == 16'h0001) return 2;
    return UNM;
  endfunction
  function automatic logic rnd(int mode);
    return mode != 0 ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction
  task automatic chk(string t, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
    end
  endtask
  task automatic timeout(string t);
    n_chk++;
    n_fail++;
    $error("FAIL %s: cycle budget expired waiting for handshake", t);
  endtask
  task automatic chk_phase(string t, int ws, logic a, logic w, logic b);
    logic d;
    d = ws == 3;
    chk({t, ".W_state"}, 32'(bus.W_state), ws);
    chk({t, ".aw_route"}, 32'(bus.aw_route), 32'(a));
    chk({t, ".w_route"}, 32'(bus.w_route), 32'(w));
    chk({t, ".b_route"}, 32'(bus.b_route), 32'(b));
    chk({t, ".wlast_err"}, 32'(bus.wlast_err), 32'(exp_err));
    chk({t, ".AWREADY_DEC"}, 32'(bus.AWREADY_DEC), 32'(d & a));
    chk({t, ".WREADY_DEC"}, 32'(bus.WREADY_DEC), 32'(d & w));
    chk({t, ".BVALID_DEC"}, 32'(bus.BVALID_DEC), 32'(d & b));
    chk({t, ".BRESP_DEC"}, 32'(bus.BRESP_DEC), (d & b) ? 32'd3 : 32'd0);
  endtask
  // mode: 0 random readies, 1 all ready, 2 WVALID high with WREADY toggling 1/0
  task automatic wr(input logic [31:0] addr, input logic [3:0] len, input int mode, input int bad_beat,
                    input int rst_beat, input bit hold, input logic [31:0] next_addr);
    int ws, beats, guard;
    logic v, r, tog;
    ws = exp_route(addr);
    chk_phase("idle", 0, 0, 0, 0);
    bus.AWADDR_M1 = addr;
    bus.AWLEN_M1 = len;
    bus.AWVALID_M1 = 1'b1;
    @(negedge ACLK);
    bus.AWADDR_M1 = $urandom;
    guard = 0;
    forever begin
      chk_phase("aw", ws, 1, 0, 0);
      r = rnd(mode);
      bus.AWREADY_M1 = r;
      @(negedge ACLK);
      if (r) break;
      if (++guard > 100) begin timeout("aw"); return; end
    end
    bus.AWVALID_M1 = 1'b0;
    bus.AWREADY_M1 = 1'b0;
    bus.AWLEN_M1 = 4'($urandom);
    beats = 0;
    guard = 0;
    tog = 1'b1;
    while (beats <= int'(len)) begin
      chk_phase("w", ws, 0, 1, 0);
      if (beats == rst_beat) begin
        ARESET = 1'b1;
        bus.WVALID_M1 = 1'b1;
        bus.WREADY_M1 = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        bus.WVALID_M1 = 1'b0;
        bus.WREADY_M1 = 1'b0;
        exp_err = 1'b0;
        chk_phase("rst", 0, 0, 0, 0);
        return;
      end
      v = mode == 2 ? 1'b1 : rnd(mode);
      r = mode == 2 ? tog : rnd(mode);
      tog = ~tog;
      bus.WLAST_M1 = (beats == bad_beat) ^ (beats == int'(len));
      bus.WVALID_M1 = v;
      bus.WREADY_M1 = r;
      @(negedge ACLK);
      if (v & r) begin
        if (beats == bad_beat) exp_err = 1'b1;
        beats++;
      end
      if (++guard > 200) begin timeout("w"); return; end
    end
    bus.WVALID_M1 = 1'b0;
    bus.WREADY_M1 = 1'b0;
    bus.WLAST_M1 = 1'b0;
    guard = 0;
    forever begin
      chk_phase("b", ws, 0, 0, 1);
      v = rnd(mode);
      r = rnd(mode);
      bus.BVALID_M1 = v;
      bus.BREADY_M1 = r;
      if (hold) begin
        bus.AWVALID_M1 = 1'b1;
        bus.AWADDR_M1 = next_addr;
      end
      @(negedge ACLK);
      if (v & r) break;
      if (++guard > 100) begin timeout("b"); return; end
    end
    bus.BVALID_M1 = 1'b0;
    bus.BREADY_M1 = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] cur, nxt;
    logic [3:0] len;
    int bad;
    bit hold;
    bus.AWADDR_M1 = '0;
    bus.AWLEN_M1 = '0;
    bus.AWVALID_M1 = 1'b0;
    bus.AWREADY_M1 = 1'b0;
    bus.WVALID_M1 = 1'b0;
    bus.WREADY_M1 = 1'b0;
    bus.WLAST_M1 = 1'b0;
    bus.BVALID_M1 = 1'b0;
    bus.BREADY_M1 = 1'b0;
    repeat (2) @(negedge ACLK);
    chk_phase("reset", 0, 0, 0, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    wr(32'h0000_0010, 4'd0, 1, -1, -1, 0, 0);
    wr(32'h0001_0040, 4'd3, 2, -1, -1, 0, 0);
    wr(32'h0000_0100, 4'd1, 1, 0, -1, 0, 0);
    wr(32'h0002_0000, 4'd0, 1, -1, -1, 0, 0);
    wr(32'h0000_0200, 4'd7, 1, -1, 2, 0, 0);
    wr(32'h0001_0000, 4'd15, 0, -1, -1, 0, 0);
    wr(32'h0001_0080, 4'd0, 1, -1, -1, 1, 32'h0000_0300);
    wr(32'h0000_0300, 4'd2, 0, -1, -1, 1, 32'h0003_1234);
    wr(32'h0003_1234, 4'd1, 0, -1, -1, 0, 0);
    cur = 32'h0000_0400;
    repeat (25) begin
      case ($urandom_range(0, 2))
        0: nxt = {16'h0000, 16'($urandom)};
        1: nxt = {16'h0001, 16'($urandom)};
        default: nxt = $urandom;
      endcase
      len = 4'($urandom);
      bad = $urandom_range(0, 5) == 0 ? $urandom_range(0, int'(len)) : -1;
      hold = 1'($urandom_range(0, 1));
      wr(cur, len, 0, bad, -1, hold, nxt);
      cur = nxt;
    end
    chk_phase("final", 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
